// File: rtl/main_mem_responder_if.sv
// Purpose: cache<->main-memory request/response bundle (request, write beat, read beat).
// Latency: none, wires only.
// Backpressure: request and write beat use valid/ready; the read response has none.
// Ports (master = initiator / cache side, slave = responder / memory side):
//   mem_req_valid/ready/addr/rw               request channel
//   mem_req_data_valid/ready/bits/mask        write beat channel, mask bit i -> byte i
//   mem_resp_valid/data                       read beat channel
interface main_mem_responder_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic                   mem_req_rw;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/main_mem_responder.sv
// Purpose: main-memory responder with byte-masked writes and fixed-length read bursts.
// Latency: write commits on the data edge; read beat j appears READ_LATENCY+j cycles after acceptance.
// Backpressure: one operation at a time via mem_req_ready/mem_req_data_ready; responses are never stalled.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   bus (slave)    request, write-beat and read-response channels (see main_mem_responder_if)
module main_mem_responder #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4,
    parameter int BEATS        = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    main_mem_responder_if.slave   bus
);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int WAIT_W    = $clog2(READ_LATENCY + 1);
    localparam int BEAT_W    = $clog2(BEATS + 1);
    // Low index bits selecting the beat within an aligned burst group.
    localparam logic [DEPTH_LOG2-1:0] OFF_MASK = DEPTH_LOG2'(BEATS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WDATA  = 2'd1;
    localparam logic [1:0] S_RWAIT  = 2'd2;
    localparam logic [1:0] S_RBURST = 2'd3;

    logic [1:0]            state_q,      state_d;
    logic [WAIT_W-1:0]     wait_cnt_q,   wait_cnt_d;
    logic [BEAT_W-1:0]     beat_cnt_q,   beat_cnt_d;
    // Latched write address in WDATA, aligned burst base in RWAIT/RBURST.
    logic [DEPTH_LOG2-1:0] base_q,       base_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_BITS-1:0]  resp_data_q,  resp_data_d;

    logic [DATA_BITS-1:0]  storage_q [2**DEPTH_LOG2];

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_fire;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the same storage.
    assign req_idx        = bus.mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^bus.mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign req_fire = bus.mem_req_valid && (state_q == S_IDLE);

    // OR-ing the beat offset into the aligned base keeps every beat inside its group.
    assign rd_idx = base_q | (DEPTH_LOG2'(beat_cnt_q) & OFF_MASK);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        base_d       = base_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        wr_en        = 1'b0;
        wr_idx       = base_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (bus.mem_req_rw) begin
                        if (bus.mem_req_data_valid) begin
                            wr_en  = 1'b1;
                            wr_idx = req_idx;
                        end else begin
                            base_d  = req_idx;
                            state_d = S_WDATA;
                        end
                    end else begin
                        base_d     = req_idx & ~OFF_MASK;
                        wait_cnt_d = '0;
                        beat_cnt_d = '0;
                        state_d    = S_RWAIT;
                    end
                end
            end
            S_WDATA: begin
                if (bus.mem_req_data_valid) begin
                    wr_en   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RWAIT: begin
                // The acceptance edge clears the counter, so beat 0 is registered
                // on the READ_LATENCY-th edge after acceptance.
                if (wait_cnt_q == WAIT_W'(READ_LATENCY - 1)) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = storage_q[rd_idx];
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                    state_d      = S_RBURST;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RBURST: begin
                if (beat_cnt_q == BEAT_W'(BEATS)) begin
                    state_d = S_IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = storage_q[rd_idx];
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins: nothing commits while reset_n is low.
        if (!reset_n) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            base_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            base_q       <= base_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Storage is deliberately not reset; only masked bytes are written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (bus.mem_req_data_mask[i]) begin
                    storage_q[wr_idx][8*i +: 8] <= bus.mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_req_ready      = reset_n && (state_q == S_IDLE);
    assign bus.mem_req_data_ready = reset_n && ((state_q == S_IDLE) || (state_q == S_WDATA));
    assign bus.mem_resp_valid     = resp_valid_q;
    assign bus.mem_resp_data      = resp_data_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Purpose: directed scoreboard bench for main_mem_responder.
// Latency: expects read beat j READ_LATENCY+j cycles after acceptance.
// Backpressure: the response channel is monitored every cycle; any unexpected beat is an error.
module tb_main_mem_responder;
    localparam int L = 4;
    localparam int B = 4;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    main_mem_responder_if #(.ADDR_BITS(28), .DATA_BITS(128)) bus();

    main_mem_responder #(
        .ADDR_BITS(28), .DATA_BITS(128), .DEPTH_LOG2(12),
        .READ_LATENCY(L), .BEATS(B)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected read beats with their expected cycle.
    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];
    string        exp_nm_q[$];

    // Reference memory contents written so far.
    logic [127:0] model [int];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        logic [127:0] e;
        int           ec;
        string        en;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %h at cycle %0d, expected no beat",
                             bus.mem_resp_data, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    en = exp_nm_q.pop_front();
                    chk({en, "_data"}, bus.mem_resp_data, e);
                    chk({en, "_cycle"}, 128'(cyc), 128'(ec));
                end
            end
        end
    end

    task automatic model_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        logic [127:0] t;
        int           k;
        k = int'(a[11:0]);
        t = model.exists(k) ? model[k] : 'x;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) t[8*i +: 8] = d[8*i +: 8];
        end
        model[k] = t;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_data_valid = 1'b0;
    endtask

    // Same-cycle write; consecutive calls give back-to-back writes.
    task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        @(negedge clk);
        bus.mem_req_valid      = 1'b1;
        bus.mem_req_rw         = 1'b1;
        bus.mem_req_addr       = a;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        model_write(a, d, m);
    endtask

    task automatic do_write_late(input logic [27:0] a, input logic [127:0] d,
                                 input logic [15:0] m, input int delay);
        @(negedge clk);
        bus.mem_req_valid      = 1'b1;
        bus.mem_req_rw         = 1'b1;
        bus.mem_req_addr       = a;
        bus.mem_req_data_valid = 1'b0;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            bus.mem_req_valid = 1'b0;
            chk("wdata_wait_req_ready", 128'(bus.mem_req_ready), 128'(0));
            chk("wdata_wait_data_ready", 128'(bus.mem_req_data_ready), 128'(1));
        end
        @(negedge clk);
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_addr       = 28'h0;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        model_write(a, d, m);
        @(negedge clk);
        bus.mem_req_data_valid = 1'b0;
        chk("wdata_done_req_ready", 128'(bus.mem_req_ready), 128'(1));
    endtask

    task automatic do_read(input logic [27:0] a, input string nm, input int nbeats,
                           input bit use_lit, input logic [127:0] lit0);
        logic [11:0] base;
        int          acc;
        base = a[11:0] & ~12'h3;
        @(negedge clk);
        bus.mem_req_valid      = 1'b1;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_addr       = a;
        bus.mem_req_data_valid = 1'b0;
        acc = cyc + 1;
        for (int j = 0; j < nbeats; j++) begin
            if (j == 0 && use_lit) exp_q.push_back(lit0);
            else                   exp_q.push_back(model[int'(base | 12'(j))]);
            exp_cyc_q.push_back(acc + L + j);
            exp_nm_q.push_back($sformatf("%s_beat%0d", nm, j));
        end
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
    endtask

    task automatic wait_burst(input string nm);
        int           t;
        logic [127:0] last;
        last = exp_q[$];
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d beats outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
            exp_nm_q.delete();
        end
        @(negedge clk);
        chk({nm, "_ready_after"}, 128'(bus.mem_req_ready), 128'(1));
        chk({nm, "_valid_after"}, 128'(bus.mem_resp_valid), 128'(0));
        chk({nm, "_hold_last"}, bus.mem_resp_data, last);
    endtask

    localparam logic [127:0] PAT_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] EXP_3 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset_n                = 1'b0;
        bus.mem_req_valid      = 1'b1;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_addr       = 28'h10;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;

        // 1: reset with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_req_ready", 128'(bus.mem_req_ready), 128'(0));
        end
        chk("reset_resp_valid", 128'(bus.mem_resp_valid), 128'(0));
        chk("reset_resp_data", bus.mem_resp_data, 128'(0));
        chk("reset_data_ready", 128'(bus.mem_req_data_ready), 128'(0));
        @(negedge clk);
        reset_n           = 1'b1;
        bus.mem_req_valid = 1'b0;

        // 2: full-mask write then read the group back
        do_write(28'h10, PAT_A, 16'hFFFF);
        do_write(28'h11, 128'h11111111_22222222_33333333_44444444, 16'hFFFF);
        do_write(28'h12, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 16'hFFFF);
        do_write(28'h13, 128'hDEADBEEF_CAFEF00D_01020304_05060708, 16'hFFFF);
        drive_idle();
        do_read(28'h10, "rd10", B, 1'b1, PAT_A);
        wait_burst("rd10");

        // 3: partial-mask write over all-ones
        do_write(28'h20, {128{1'b1}}, 16'hFFFF);
        do_write(28'h21, 128'h21, 16'hFFFF);
        do_write(28'h22, 128'h22, 16'hFFFF);
        do_write(28'h23, 128'h23, 16'hFFFF);
        do_write(28'h20, 128'h0, 16'h000F);
        drive_idle();
        do_read(28'h20, "rd20", B, 1'b1, EXP_3);
        wait_burst("rd20");

        // 4: write request with data three cycles late
        do_write(28'h31, 128'h31, 16'hFFFF);
        do_write(28'h32, 128'h32, 16'hFFFF);
        do_write(28'h33, 128'h33, 16'hFFFF);
        drive_idle();
        do_write_late(28'h30, 128'hFEEDFACE_0BADF00D_12345678_9ABCDEF0, 16'hFFFF, 3);
        do_read(28'h30, "rd30", B, 1'b1, 128'hFEEDFACE_0BADF00D_12345678_9ABCDEF0);
        wait_burst("rd30");

        // Stray write beat with no request must not touch storage.
        @(negedge clk);
        bus.mem_req_addr       = 28'h10;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = 128'h0;
        bus.mem_req_data_mask  = 16'hFFFF;
        drive_idle();

        // Alternating byte mask, aliased upper address bits
        do_write(28'hABC_0012, {16{8'h77}}, 16'hF0F0);
        drive_idle();

        // 5: unaligned read returns the aligned group in order
        do_read(28'h13, "rd13", B, 1'b0, '0);
        wait_burst("rd13");

        // 6: reset after beat 1 of a burst
        do_read(28'h10, "rdrst", 2, 1'b0, '0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_resp_valid", 128'(bus.mem_resp_valid), 128'(0));
        chk("midreset_req_ready", 128'(bus.mem_req_ready), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postreset_req_ready", 128'(bus.mem_req_ready), 128'(1));
        do_read(28'h10, "rdpost", B, 1'b1, PAT_A);
        wait_burst("rdpost");

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
